// File: rtl/jtdd_mainrom_rq.sv
// Two-entry fully associative word cache in front of SDRAM for the main CPU ROM.
// Misses fetch one 16-bit word through a req/ack/valid handshake; flush invalidates everything.
module jtdd_mainrom_rq #(
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_cs,
   input  logic [AW-1:0] cpu_addr,
   output logic          cpu_ok,
   output logic [7:0]    cpu_data,
   input  logic          flush,
   output logic          sdram_req,
   output logic [AW-2:0] sdram_addr,
   input  logic          sdram_ack,
   input  logic          sdram_valid,
   input  logic [15:0]   sdram_din
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

   state_t               state, nx_state;
   logic [1:0]           valid;
   logic [1:0][AW-2:0]   tag;
   logic [1:0][15:0]     data;
   logic                 ptr;
   logic                 stale;
   logic [1:0]           match;
   logic                 hit;
   logic [15:0]          hit_word;
   logic                 start;
   logic                 fill;

   always_comb begin
      for (int i = 0; i < 2; i++)
         match[i] = valid[i] && (tag[i] == cpu_addr[AW-1:1]);
      hit      = cpu_cs && (|match);
      hit_word = match[0] ? data[0] : data[1];
      cpu_ok   = hit;
      if (!hit)
         cpu_data = 8'hff;
      else if (cpu_addr[0])
         cpu_data = hit_word[15:8];
      else
         cpu_data = hit_word[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nx_state;
   end

   always_comb begin
      nx_state = state;
      start    = 1'b0;
      fill     = 1'b0;
      case (state)
         IDLE:
            if (cpu_cs && !hit && !flush) begin
               start    = 1'b1;
               nx_state = WAIT_ACK;
            end
         WAIT_ACK:
            if (sdram_ack) nx_state = WAIT_DATA;
         WAIT_DATA:
            if (sdram_valid) begin
               nx_state = IDLE;
               // a flush seen at any point of the fetch, including this cycle, drops the word
               fill     = !stale && !flush;
            end
         default: nx_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         valid      <= 2'b00;
         tag        <= '0;
         data       <= '0;
         ptr        <= 1'b0;
         stale      <= 1'b0;
      end else begin
         if (start) begin
            sdram_req  <= 1'b1;
            sdram_addr <= cpu_addr[AW-1:1];
         end
         if (state == WAIT_ACK && sdram_ack)
            sdram_req <= 1'b0;
         if (fill) begin
            valid[ptr] <= 1'b1;
            tag[ptr]   <= sdram_addr;
            data[ptr]  <= sdram_din;
            ptr        <= ~ptr;
         end
         if (flush)
            valid <= 2'b00;
         if (state == WAIT_DATA && sdram_valid)
            stale <= 1'b0;
         else if (state != IDLE && flush)
            stale <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtdd_mainrom_rq.sv
// Bench for jtdd_mainrom_rq: directed scenarios then random accesses, checked against
// a cache model kept as an ordered list of the last two committed fills.
module tb_jtdd_mainrom_rq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_cs = 1'b0;
   logic [17:0] cpu_addr = '0;
   logic        cpu_ok;
   logic [7:0]  cpu_data;
   logic        flush = 1'b0;
   logic        sdram_req;
   logic [16:0] sdram_addr;
   logic        sdram_ack = 1'b0;
   logic        sdram_valid = 1'b0;
   logic [15:0] sdram_din = '0;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct { logic [16:0] tag; logic [15:0] data; } ent_t;
   ent_t q[$];

   jtdd_mainrom_rq #(.AW(18)) dut (
      .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_addr(cpu_addr),
      .cpu_ok(cpu_ok), .cpu_data(cpu_data), .flush(flush),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .sdram_valid(sdram_valid), .sdram_din(sdram_din)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: a byte hits if any remembered fill covers its word.
   function automatic bit m_hit(input logic [17:0] a, output logic [7:0] b);
      b = 8'hff;
      foreach (q[i])
         if (q[i].tag == a[17:1]) begin
            b = a[0] ? q[i].data[15:8] : q[i].data[7:0];
            return 1'b1;
         end
      return 1'b0;
   endfunction

   task automatic chk_hit(input string tag, input logic [17:0] a, input bit cs);
      logic [7:0] b;
      bit h;
      h = m_hit(a, b);
      chk({tag, "_ok"}, cpu_ok, cs && h);
      chk({tag, "_data"}, cpu_data, (cs && h) ? b : 8'hff);
   endtask

   // Entry: DUT idle, just after a clock edge, address a missing in the cache.
   task automatic fetch(input logic [17:0] a, input int ack_dly, input int val_dly,
                        input logic [15:0] din, input int flush_at, input bit fl_ack,
                        input logic [17:0] alt, input bit alt_cs);
      ent_t e;
      cpu_cs = 1'b1; cpu_addr = a; #1;
      chk("miss_ok", cpu_ok, 1'b0);
      chk("miss_data", cpu_data, 8'hff);
      chk("idle_req", sdram_req, 1'b0);
      cyc();
      for (int i = 0; i <= ack_dly; i++) begin
         chk("req_hold", sdram_req, 1'b1);
         chk("req_addr", sdram_addr, a[17:1]);
         sdram_valid = (i == 0 && ack_dly > 0);
         sdram_ack   = (i == ack_dly);
         flush       = fl_ack && (i == ack_dly);
         cyc();
      end
      sdram_ack = 1'b0; sdram_valid = 1'b0; flush = 1'b0;
      cpu_addr = alt; cpu_cs = alt_cs; #1;
      chk("req_drop", sdram_req, 1'b0);
      for (int i = 0; i <= val_dly; i++) begin
         sdram_ack   = (i == 0 && val_dly > 0);
         sdram_valid = (i == val_dly);
         sdram_din   = din;
         flush       = (i == flush_at);
         cyc();
      end
      sdram_ack = 1'b0; sdram_valid = 1'b0; flush = 1'b0;
      if (fl_ack || flush_at >= 0) begin
         q.delete();
      end else begin
         e.tag = a[17:1]; e.data = din;
         q.push_back(e);
         if (q.size() > 2) void'(q.pop_front());
      end
      #1;
      chk("gap_req", sdram_req, 1'b0);
      chk_hit("fill", alt, alt_cs);
   endtask

   task automatic idle_flush(input logic [17:0] a);
      cpu_cs = 1'b1; cpu_addr = a; flush = 1'b1;
      cyc();
      flush = 1'b0;
      q.delete();
      #1;
      chk("flush_noreq", sdram_req, 1'b0);
      chk("flush_ok", cpu_ok, 1'b0);
      cpu_cs = 1'b0;
      cyc();
   endtask

   task automatic access(input logic [17:0] a);
      logic [7:0] b;
      int r, fa;
      bit fl;
      if (m_hit(a, b)) begin
         cpu_cs = 1'b1; cpu_addr = a;
         sdram_ack = $urandom_range(0, 1); sdram_valid = $urandom_range(0, 1);
         #1;
         chk_hit("hit", a, 1'b1);
         cyc();
         sdram_ack = 1'b0; sdram_valid = 1'b0;
         chk("hit_noreq", sdram_req, 1'b0);
      end else begin
         r  = $urandom_range(0, 3);
         fa = $urandom_range(0, 9);
         fl = (fa == 1);
         fetch(a, $urandom_range(0, 3), r, 16'($urandom),
               (fa == 0) ? $urandom_range(0, r) : -1, fl,
               18'h30000 + 18'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         cpu_cs = 1'b0;
         cyc();
      end
   endtask

   initial begin
      cyc(); cyc();
      chk("rst_req", sdram_req, 1'b0);
      chk("rst_addr", sdram_addr, 17'h0);
      chk("rst_ok", cpu_ok, 1'b0);
      chk("rst_data", cpu_data, 8'hff);
      rst = 1'b0;
      cyc();

      // cold miss, upper byte
      fetch(18'h20001, 3, 2, 16'hA55A, -1, 1'b0, 18'h20001, 1'b1);
      chk("cold_data", cpu_data, 8'hA5);
      cpu_cs = 1'b0; cyc();
      // lower byte hit, no request
      cpu_cs = 1'b1; cpu_addr = 18'h20000; #1;
      chk("lo_ok", cpu_ok, 1'b1);
      chk("lo_data", cpu_data, 8'h5A);
      cyc();
      chk("lo_noreq", sdram_req, 1'b0);
      cpu_cs = 1'b0; cyc();

      // replacement: third fill evicts the oldest word
      fetch(18'h20002, 1, 1, 16'h1111, -1, 1'b0, 18'h20000, 1'b1);
      cpu_cs = 1'b0; cyc();
      fetch(18'h20004, 0, 0, 16'h2222, -1, 1'b0, 18'h20000, 1'b1);
      chk("evict_ok", cpu_ok, 1'b0);
      cpu_cs = 1'b0; cyc();
      access(18'h20003);
      access(18'h20005);
      fetch(18'h20000, 2, 1, 16'hA55A, -1, 1'b0, 18'h20003, 1'b1);
      cpu_cs = 1'b0; cyc();

      // flush in WAIT_DATA discards the fill; same word is requested again
      fetch(18'h20010, 1, 2, 16'h3333, 1, 1'b0, 18'h20010, 1'b1);
      chk("stale_ok", cpu_ok, 1'b0);
      fetch(18'h20010, 0, 1, 16'h4444, -1, 1'b0, 18'h20010, 1'b1);
      cpu_cs = 1'b0; cyc();

      // address change mid-fetch: old word fills, new word follows after one idle cycle
      fetch(18'h00010, 1, 2, 16'h5678, -1, 1'b0, 18'h00020, 1'b1);
      fetch(18'h00020, 1, 1, 16'h9abc, -1, 1'b0, 18'h00010, 1'b1);
      chk("chain_data", cpu_data, 8'h78);
      cpu_cs = 1'b0; cyc();

      idle_flush(18'h00010);

      // reset mid-fetch, then stray handshake pulses
      cpu_cs = 1'b1; cpu_addr = 18'h15554;
      cyc();
      chk("prerst_req", sdram_req, 1'b1);
      rst = 1'b1; #1;
      chk("async_rst_req", sdram_req, 1'b0);
      cyc();
      rst = 1'b0; cpu_cs = 1'b0; q.delete();
      sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
      sdram_valid = 1'b1; sdram_din = 16'h1234; cyc(); sdram_valid = 1'b0;
      chk("rst_stray_req", sdram_req, 1'b0);
      cpu_cs = 1'b1; cpu_addr = 18'h15554; #1;
      chk("rst_stray_ok", cpu_ok, 1'b0);
      chk("rst_stray_data", cpu_data, 8'hff);
      cpu_addr = 18'h00010; #1;
      chk("rst_clr_ok", cpu_ok, 1'b0);
      cpu_cs = 1'b0; cyc();

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 11) == 0)
            idle_flush(18'h30000 + 18'($urandom_range(0, 7)));
         access(18'h30000 + 18'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
